// File: rtl/ota_pkg.sv
// Shared definitions for the differential OTA stimulus transmitter.
// Holds the output-driver and modulator state enums plus default sizing.
package ota_pkg;

  localparam int W_DEFAULT    = 8;  // code width, frame = 2^W cycles
  localparam int DEAD_DEFAULT = 1;  // dead-time cycles on polarity change

  // Output driver states: OFF and DEAD keep both pads low.
  typedef enum logic [1:0] {
    OUT_OFF  = 2'd0,
    OUT_POS  = 2'd1,
    OUT_NEG  = 2'd2,
    OUT_DEAD = 2'd3
  } out_state_t;

  // Modulator states.
  typedef enum logic {
    MOD_IDLE = 1'b0,
    MOD_RUN  = 1'b1
  } mod_state_t;

endpackage

// File: rtl/ota_deadtime_drv.sv
// Complementary pad driver with dead-time insertion.
// Turns the modulator bit into p_out/n_out so that the two pads are never
// high in the same cycle; a polarity change passes through DEAD cycles with
// both pads low.
//   clk, rst : clock, asynchronous active-high reset
//   run      : modulator running; low forces OFF on the next edge
//   target   : modulator bit, 1 -> POS, 0 -> NEG
//   p_out    : positive pad drive (Vip)
//   n_out    : negative pad drive (Vin)
module ota_deadtime_drv
  import ota_pkg::*;
#(
  parameter int DEAD = DEAD_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic target,
  output logic p_out,
  output logic n_out
);

  localparam logic [1:0] DEAD_LOAD = (DEAD > 0) ? 2'(DEAD - 1) : 2'd0;

  out_state_t state, state_next;
  logic [1:0] dead_cnt, dead_cnt_next;
  out_state_t tgt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= OUT_OFF;
      dead_cnt <= 2'd0;
    end else begin
      state    <= state_next;
      dead_cnt <= dead_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    dead_cnt_next = dead_cnt;
    tgt           = target ? OUT_POS : OUT_NEG;
    if (!run) begin
      // Stopping always wins, even in the middle of a dead window.
      state_next    = OUT_OFF;
      dead_cnt_next = 2'd0;
    end else begin
      case (state)
        OUT_OFF: state_next = tgt;
        OUT_POS, OUT_NEG: begin
          if (tgt != state) begin
            if (DEAD > 0) begin
              state_next    = OUT_DEAD;
              dead_cnt_next = DEAD_LOAD;
            end else begin
              state_next = tgt;
            end
          end
        end
        OUT_DEAD: begin
          // Target is only looked at when the window expires.
          if (dead_cnt == 2'd0) state_next = tgt;
          else                  dead_cnt_next = dead_cnt - 2'd1;
        end
        default: state_next = OUT_OFF;
      endcase
    end
  end

  always_comb begin
    p_out = (state == OUT_POS);
    n_out = (state == OUT_NEG);
  end

endmodule

// File: rtl/ota_diff_stim_tx.sv
// Differential OTA stimulus transmitter.
// Accepts W-bit codes over valid/ready into a pending slot, runs a
// first-order sigma-delta modulator over 2^W-cycle frames (ones per frame
// equal the code), and drives complementary pads through a dead-time driver.
//   clk, rst   : clock, asynchronous active-high reset
//   en         : run enable
//   code_data  : next code; code_valid qualifies it
//   code_ready : pending slot is free
//   p_out/n_out: complementary pad drives (Vip/Vin)
//   busy       : modulator in RUN
//   frame_done : pulse on the last cycle of each frame
//   underrun   : sticky, a frame ended with no pending code
module ota_diff_stim_tx
  import ota_pkg::*;
#(
  parameter int W    = W_DEFAULT,
  parameter int DEAD = DEAD_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] code_data,
  input  logic         code_valid,
  output logic         code_ready,
  output logic         p_out,
  output logic         n_out,
  output logic         busy,
  output logic         frame_done,
  output logic         underrun
);

  localparam logic [W-1:0] CNT_LAST = {W{1'b1}};

  mod_state_t   state, state_next;
  logic [W-1:0] acc;
  logic [W-1:0] frame_cnt;
  logic [W-1:0] active;
  logic [W-1:0] pending;
  logic         pending_full;
  logic [W:0]   sum;
  logic         mod_bit;
  logic         frame_end;
  logic         start;
  logic         step;
  logic         accept;
  logic         run;

  assign sum        = {1'b0, acc} + {1'b0, active};
  assign mod_bit    = sum[W];
  assign code_ready = !pending_full;
  assign accept     = code_valid && code_ready;
  assign frame_end  = (state == MOD_RUN) && (frame_cnt == CNT_LAST);
  assign start      = (state == MOD_IDLE) && en && pending_full;
  assign step       = (state == MOD_RUN) && en;

  // Modulator state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MOD_IDLE;
    else     state <= state_next;
  end

  // Modulator next state
  always_comb begin
    state_next = state;
    case (state)
      MOD_IDLE: if (en && pending_full) state_next = MOD_RUN;
      MOD_RUN:  if (!en)                state_next = MOD_IDLE;
      default:                          state_next = MOD_IDLE;
    endcase
  end

  // Modulator outputs; frame_done ignores en so a frame end still pulses
  // in the same cycle that en drops.
  always_comb begin
    busy       = (state == MOD_RUN);
    frame_done = frame_end;
    run        = step;
  end

  // Control state: accumulator, frame counter, slot flag, underrun.
  // The slot is only set when empty and only cleared when full, so the two
  // updates below never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc          <= '0;
      frame_cnt    <= '0;
      pending_full <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      if (start) begin
        acc          <= '0;
        frame_cnt    <= '0;
        pending_full <= 1'b0;
      end else if (state == MOD_RUN) begin
        if (!en) begin
          acc       <= '0;
          frame_cnt <= '0;
        end else begin
          acc       <= sum[W-1:0];
          frame_cnt <= frame_cnt + 1'b1;
          if (frame_end) begin
            if (pending_full) pending_full <= 1'b0;
            else              underrun     <= 1'b1;
          end
        end
      end
      if (accept) pending_full <= 1'b1;
    end
  end

  // Code registers; contents are meaningless until qualified by the flags.
  always_ff @(posedge clk) begin
    if (accept) pending <= code_data;
    if (start || (step && frame_end && pending_full)) active <= pending;
  end

  ota_deadtime_drv #(
    .DEAD (DEAD)
  ) u_drv (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .target (mod_bit),
    .p_out  (p_out),
    .n_out  (n_out)
  );

endmodule

// File: tb/tb_ota_diff_stim_tx.sv
// Bench for ota_diff_stim_tx: two instances share stimulus, one with no
// dead time and one with DEAD=2. Expected pulse streams come from the
// pulse-density rule floor((k+1)c/2^W) - floor(kc/2^W).
module tb_ota_diff_stim_tx;

  localparam int W     = 8;
  localparam int FRAME = 256;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic [W-1:0] code_data = '0;
  logic         code_valid = 1'b0;
  logic         ready0, p0, n0, busy0, fd0, ur0;
  logic         ready2, p2, n2, busy2, fd2, ur2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ota_diff_stim_tx #(.W(W), .DEAD(0)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .code_data(code_data), .code_valid(code_valid),
    .code_ready(ready0), .p_out(p0), .n_out(n0), .busy(busy0),
    .frame_done(fd0), .underrun(ur0)
  );

  ota_diff_stim_tx #(.W(W), .DEAD(2)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .code_data(code_data), .code_valid(code_valid),
    .code_ready(ready2), .p_out(p2), .n_out(n2), .busy(busy2),
    .frame_done(fd2), .underrun(ur2)
  );

  // Pads must never overlap, in any cycle and either instance.
  always @(negedge clk) begin
    checks++;
    if (((p0 & n0) | (p2 & n2)) !== 1'b0) begin
      errors++;
      $display("FAIL overlap p0=%b n0=%b p2=%b n2=%b required no both-high", p0, n0, p2, n2);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  function automatic int model_bit(input int c, input int k);
    return ((k + 1) * c) / FRAME - (k * c) / FRAME;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic restart;
    rst = 1'b1;
    code_valid = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic send(input int c);
    int guard = 0;
    code_data  = W'(c);
    code_valid = 1'b1;
    while (!ready0 && guard < 1000) begin
      tick;
      guard++;
    end
    if (guard >= 1000) begin
      checks++; errors++;
      $display("FAIL send_timeout code_ready=%b required 1", ready0);
    end
    tick;
    code_valid = 1'b0;
  endtask

  task automatic wait_fd(input string name);
    int guard = 0;
    while (!fd0 && guard < 600) begin
      tick;
      guard++;
    end
    checks++;
    if (!fd0) begin
      errors++;
      $display("FAIL %s frame_done_timeout got %b required 1", name, fd0);
    end
  endtask

  // Samples one frame of pad output, aligned so sample i shows frame bit i.
  task automatic measure(input int c, output int ones, output int done_idx,
                         output int bad_model, output int bad_comp);
    ones = 0; done_idx = -1; bad_model = 0; bad_comp = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick;
      if (p0) ones++;
      if (fd0 && done_idx < 0) done_idx = i;
      if (n0 !== !p0) bad_comp++;
      if (int'(p0) != model_bit(c, i)) bad_model++;
    end
  endtask

  task automatic check_frame(input string name, input int c);
    int ones, didx, bm, bc;
    measure(c, ones, didx, bm, bc);
    checks++;
    if (ones !== c) begin errors++; $display("FAIL %s ones got %0d required %0d", name, ones, c); end
    checks++;
    if (didx !== FRAME - 2) begin errors++; $display("FAIL %s frame_done_pos got %0d required %0d", name, didx, FRAME - 2); end
    checks++;
    if (bm !== 0) begin errors++; $display("FAIL %s stream_vs_model bad_cycles got %0d required 0", name, bm); end
    checks++;
    if (bc !== 0) begin errors++; $display("FAIL %s n_not_complement bad_cycles got %0d required 0", name, bc); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    checks++;
    if ({p0, n0, ready0, busy0, fd0, ur0} !== 6'b001000) begin
      errors++;
      $display("FAIL reset_state got p=%b n=%b rdy=%b busy=%b fd=%b ur=%b required 0 0 1 0 0 0",
               p0, n0, ready0, busy0, fd0, ur0);
    end
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_half_scale;
    restart;
    en = 1'b1;
    send(128);
    checks++;
    if ({busy0, ready0} !== 2'b00) begin errors++; $display("FAIL half_accept busy=%b rdy=%b required 0 0", busy0, ready0); end
    tick;
    checks++;
    if ({busy0, ready0} !== 2'b11) begin errors++; $display("FAIL half_start busy=%b rdy=%b required 1 1", busy0, ready0); end
    check_frame("half_f1", 128);
    check_frame("half_f2", 128);
  endtask

  task automatic test_codes;
    int codes[5];
    codes[0] = 0;
    codes[1] = 255;
    codes[2] = $urandom_range(1, 254);
    codes[3] = $urandom_range(1, 254);
    codes[4] = 1;
    for (int j = 0; j < 5; j++) begin
      restart;
      send(codes[j]);
      tick;
      checks++;
      if (busy0 !== 1'b1) begin errors++; $display("FAIL code_start busy=%b required 1", busy0); end
      check_frame($sformatf("code_%0d", codes[j]), codes[j]);
    end
  endtask

  task automatic test_dead_time;
    int cs[2];
    cs[0] = 64;
    cs[1] = 128;
    for (int j = 0; j < 2; j++) begin
      int prev_hi, zrun, bad, changes, runs, cur;
      prev_hi = 0; zrun = 0; bad = 0; changes = 0; runs = 0;
      restart;
      send(cs[j]);
      tick;
      for (int i = 0; i < 2 * FRAME; i++) begin
        tick;
        cur = p2 ? 1 : (n2 ? 2 : 0);
        if (cur != 0) begin
          if (prev_hi != 0 && zrun != 0) begin
            runs++;
            if (zrun != 2) bad++;
          end
          if (prev_hi != 0 && cur != prev_hi) begin
            changes++;
            if (zrun != 2) bad++;
          end
          zrun = 0;
          prev_hi = cur;
        end else begin
          zrun++;
        end
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL dead_%0d bad_gaps got %0d required 0", cs[j], bad); end
      checks++;
      if (runs == 0) begin errors++; $display("FAIL dead_%0d gap_count got %0d required >0", cs[j], runs); end
      if (cs[j] == 128) begin
        checks++;
        if (changes == 0) begin errors++; $display("FAIL dead_128 polarity_changes got %0d required >0", changes); end
      end
    end
  endtask

  task automatic test_buffering;
    int bad;
    restart;
    send(32);
    tick;
    for (int i = 0; i < 50; i++) tick;
    send(200);
    checks++;
    if (ready0 !== 1'b0) begin errors++; $display("FAIL buf_ready_after_load got %b required 0", ready0); end
    bad = 0;
    for (int g = 0; g < 600 && !fd0; g++) begin
      if (ready0 !== 1'b0) bad++;
      tick;
    end
    wait_fd("buf_f1");
    checks++;
    if ((bad != 0) || (ready0 !== 1'b0)) begin errors++; $display("FAIL buf_ready_held bad=%0d rdy=%b required 0 0", bad, ready0); end
    tick;
    checks++;
    if ({ready0, ur0} !== 2'b10) begin errors++; $display("FAIL buf_swap rdy=%b ur=%b required 1 0", ready0, ur0); end
    check_frame("buf_f2", 200);
    checks++;
    if (ur0 !== 1'b1) begin errors++; $display("FAIL buf_underrun got %b required 1", ur0); end
    check_frame("buf_f3", 200);
    // Code arriving on the frame-end cycle waits one full frame.
    wait_fd("buf_f4");
    code_data  = 8'd77;
    code_valid = 1'b1;
    tick;
    code_valid = 1'b0;
    checks++;
    if (ready0 !== 1'b0) begin errors++; $display("FAIL buf_edge_accept rdy=%b required 0", ready0); end
    check_frame("buf_f5", 200);
    check_frame("buf_f6", 77);
    checks++;
    if (ready0 !== 1'b1) begin errors++; $display("FAIL buf_edge_consumed rdy=%b required 1", ready0); end
  endtask

  task automatic test_enable_drop;
    int g;
    restart;
    send(128);
    tick;
    for (int i = 0; i < 40; i++) tick;
    send(99);
    g = 0;
    while (!p0 && g < 10) begin tick; g++; end
    checks++;
    if (p0 !== 1'b1) begin errors++; $display("FAIL en_pre p0=%b required 1", p0); end
    en = 1'b0;
    tick;
    checks++;
    if ({p0, n0, p2, n2, busy0, ready0} !== 6'b000000) begin
      errors++;
      $display("FAIL en_drop p0=%b n0=%b p2=%b n2=%b busy=%b rdy=%b required all 0", p0, n0, p2, n2, busy0, ready0);
    end
    for (int i = 0; i < 5; i++) tick;
    checks++;
    if ({busy0, fd0, p0, n0} !== 4'b0000) begin errors++; $display("FAIL en_idle busy=%b fd=%b p=%b n=%b required 0", busy0, fd0, p0, n0); end
    en = 1'b1;
    tick;
    checks++;
    if ({busy0, ready0} !== 2'b11) begin errors++; $display("FAIL en_restart busy=%b rdy=%b required 1 1", busy0, ready0); end
    check_frame("en_restart_99", 99);
    // en dropping on the frame-end cycle: pulse still seen, no underrun.
    restart;
    send(50);
    tick;
    wait_fd("en_at_end");
    en = 1'b0;
    #1;
    checks++;
    if (fd0 !== 1'b1) begin errors++; $display("FAIL en_end_pulse fd=%b required 1", fd0); end
    tick;
    checks++;
    if ({ur0, busy0, p0, n0} !== 4'b0000) begin errors++; $display("FAIL en_end_state ur=%b busy=%b p=%b n=%b required 0", ur0, busy0, p0, n0); end
    en = 1'b1;
  endtask

  task automatic test_async_reset;
    int g;
    restart;
    send(128);
    tick;
    check_frame("ar_f1", 128);
    checks++;
    if (ur0 !== 1'b1) begin errors++; $display("FAIL ar_underrun_pre got %b required 1", ur0); end
    g = 0;
    while (!p0 && g < 10) begin tick; g++; end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({p0, n0, busy0, ur0, ready0, fd0, p2, n2} !== 8'b00001000) begin
      errors++;
      $display("FAIL async_reset p=%b n=%b busy=%b ur=%b rdy=%b fd=%b p2=%b n2=%b required 0 0 0 0 1 0 0 0",
               p0, n0, busy0, ur0, ready0, fd0, p2, n2);
    end
    tick;
    rst = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_half_scale;
    test_codes;
    test_dead_time;
    test_buffering;
    test_enable_drop;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ota_diff_stim_tx.md
Name: ota_diff_stim_tx

Overview:
- Digital transmitter that drives the differential OTA input pair from an 8-bit code.
- Converts each code into a first-order sigma-delta pulse-density stream on complementary outputs p_out/n_out, which feed the Vip/Vin pads.
- Dead-time insertion guarantees the two outputs are never high together, so the OTA's one-hot enable logic never sees the overlap condition.
- Codes are accepted through a valid/ready handshake and are double-buffered per frame.

Parameters:
- W, 8, code width; frame length is 2^W cycles.
- DEAD, 1, dead-time cycles with both outputs low on each polarity change; legal range 0..3.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  run enable.
- code_data  in  W  next code.
- code_valid  in  1  code_data valid.
- code_ready  out  1  pending slot free.
- p_out  out  1  positive drive, to Vip.
- n_out  out  1  negative drive, to Vin.
- busy  out  1  high while the modulator state is RUN.
- frame_done  out  1  one-cycle pulse on the last cycle of each frame.
- underrun  out  1  sticky flag: a frame ended with no pending code.

Behaviour:
- Reset (async, rst=1) sets: p_out=0, n_out=0, code_ready=1, busy=0, frame_done=0, underrun=0, acc=0, frame_cnt=0, pending empty, modulator state IDLE, output state OFF.
- Handshake:
  - A transfer occurs when code_valid and code_ready are both high on a rising edge.
  - code_ready = !pending_full.
  - The accepted code goes into the pending register.
- Modulator FSM:
  - IDLE -> RUN when en=1 and pending is full. That cycle, pending moves to active, acc and frame_cnt clear, and pending empties.
  - In RUN, each cycle: sum = acc + active (W+1 bits); bit = sum[W]; acc <= sum[W-1:0]; frame_cnt increments and wraps at 2^W-1 -> 0.
  - Ones per frame equal the code value exactly. Code 0 gives no ones; code 2^W-1 gives 2^W-1 ones.
- Frame end (frame_cnt == 2^W-1):
  - frame_done=1 for that cycle.
  - If pending is full, the next cycle uses the new active code and pending empties; acc is not cleared.
  - If pending is empty, underrun is set and the active code repeats.
  - A code accepted in the same cycle as frame end is written to pending. It becomes active at the following frame end.
- underrun clears only on rst.
- en=0 while in RUN takes effect immediately: the modulator returns to IDLE next cycle, acc=0, frame_cnt=0, active is discarded, pending is preserved, and the output FSM goes to OFF.
- Output FSM (registered, states OFF/POS/NEG/DEAD):
  - Target is POS if bit=1, NEG if bit=0, and OFF when not in RUN.
  - From OFF, go directly to the target with no dead time.
  - From POS or NEG, when the target has the opposite polarity:
    - With DEAD>0: enter DEAD, load dead_cnt = DEAD-1, and drive p_out=n_out=0.
    - With DEAD=0: switch directly.
  - In DEAD: target changes are ignored; the counter decrements; at 0 the FSM goes to the current target.
  - Output encodings: POS drives p_out=1, n_out=0. NEG drives p_out=0, n_out=1. OFF and DEAD drive both 0.
- Invariant: p_out & n_out == 0 in every cycle, including reset and en toggling.
- Latency:
  - Code acceptance to IDLE->RUN: 1 cycle, when en=1.
  - First modulator bit: the first RUN cycle.
  - p_out/n_out reflect that bit one cycle later.
- Simultaneous events:
  - rst overrides all.
  - en=0 at frame end: en wins, frame_done still pulses, and underrun is not set.

Decomposition:
- Shared package (ota_pkg) holds:
  - Output-state enum (OFF/POS/NEG/DEAD).
  - Modulator-state enum (IDLE/RUN).
  - Default W and DEAD constants.
- One sub-module, ota_deadtime_drv: the output FSM plus dead counter. Inputs are target and run; outputs are p_out and n_out.
- Accumulator, frame counter and handshake remain in the top level.

Test Plan:
- Reset check: assert rst mid-frame while p_out=1 -> p_out, n_out, busy and underrun are 0 immediately (asynchronous), and code_ready=1.
- Half scale: code 128, DEAD=0, en=1 -> p_out alternates 1/0, 128 ones per 256-cycle frame, n_out == !p_out in every RUN cycle, frame_done every 256 cycles.
- Zero code: code 0 -> p_out=0 and n_out=1 for the whole frame; code 255 -> 255 ones per frame.
- Dead time: code 64, DEAD=2 -> exactly 2 both-low cycles before every polarity change, and p_out&n_out never 1.
- Underrun and buffering: load 32, then load 200 mid-frame -> code_ready drops until frame end, and the second frame has 200 ones. Supply no third code -> underrun=1 after the second frame and 200 repeats.
- Enable drop: en=0 mid-frame -> outputs both 0 next cycle and busy=0. Pending is kept, and en=1 restarts with frame_cnt=0.
